// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity select values,
// serial line levels and the parity equation used by both TX and RX paths.
package uart_pkg;

  // Widest data word any UART frame in this family carries.
  localparam int MAX_DATA_WIDTH = 9;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Parity type select.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Serial line levels.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Parity bit for a data word. Unused upper bits must be zero, which leaves
  // the XOR-reduce unchanged. Even parity makes the total count of ones even;
  // odd parity makes it odd.
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                      input logic                      par_typ);
    logic par_s;
    par_s = (^data) ^ (par_typ == PAR_ODD);
    return par_s;
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator for the UART transmitter. Uses the same
// package equation as the receive-side parity checker.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  logic [MAX_DATA_WIDTH-1:0] data_ext_s;

  // Zero-extend the word to the package width and apply the parity equation.
  always_comb begin
    data_ext_s = MAX_DATA_WIDTH'(data);
    parity     = parity_bit(data_ext_s, par_typ);
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer. One bit per CLK cycle: start bit, DATA_WIDTH data
// bits LSB first, optional parity bit, one stop bit. The frame contents are
// latched on acceptance so the source may change its inputs mid-frame.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e             state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_next_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic                  tx_r;
  logic                  busy_r;
  logic                  parity_s;

  assign cnt_next_s = cnt_r + CNT_ONE;

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (data_r),
    .par_typ (par_typ_r),
    .parity  (parity_s)
  );

  // Frame sequencer. The line value for the next state is computed here so
  // TX_OUT comes straight from a flop and never glitches.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      data_r    <= {DATA_WIDTH{1'b0}};
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
      tx_r      <= LINE_IDLE;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (DATA_VALID) begin
            data_r    <= P_DATA;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
            state_r   <= START;
            tx_r      <= START_BIT;
            busy_r    <= 1'b1;
          end else begin
            tx_r      <= LINE_IDLE;
            busy_r    <= 1'b0;
          end
        end
        START: begin
          state_r <= DATA;
          cnt_r   <= {CNT_W{1'b0}};
          tx_r    <= data_r[0];
          busy_r  <= 1'b1;
        end
        DATA: begin
          busy_r <= 1'b1;
          if (cnt_r == LAST_BIT) begin
            if (par_en_r) begin
              state_r <= PARITY;
              tx_r    <= parity_s;
            end else begin
              state_r <= STOP;
              tx_r    <= LINE_IDLE;
            end
          end else begin
            cnt_r <= cnt_next_s;
            tx_r  <= data_r[cnt_next_s];
          end
        end
        PARITY: begin
          state_r <= STOP;
          tx_r    <= LINE_IDLE;
          busy_r  <= 1'b1;
        end
        STOP: begin
          // BUSY drops as we enter IDLE so a new word can be accepted there.
          state_r <= IDLE;
          tx_r    <= LINE_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          tx_r    <= LINE_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_r;
  assign BUSY   = busy_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame. Inputs are driven and outputs are
// sampled on the falling edge; expected serial sequences are built from the
// frame format (start, data LSB first, parity by counting ones, stop).
module tb_uart_tx_frame;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] P_DATA = '0;
  logic         DATA_VALID = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         TX_OUT;
  logic         BUSY;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  // Sends one frame starting at a falling edge with the DUT idle, checks every
  // frame cycle and the single idle cycle that follows. Returns on that idle
  // falling edge. mode 0: quiet inputs; 1: random input churn mid-frame
  // (including DATA_VALID pulses that must be dropped); 2: DATA_VALID held.
  task automatic run_frame(input logic [W-1:0] d, input bit pe, input bit pt,
                           input int mode, input string tag);
    bit exp_q[$];
    int ones;
    bit par;
    exp_q.push_back(1'b0);
    for (int i = 0; i < W; i++) exp_q.push_back(((d >> i) & 1) != 0);
    if (pe) begin
      ones = $countones(d);
      par  = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
      exp_q.push_back(par);
    end
    exp_q.push_back(1'b1);

    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== exp_q[i] || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL %s cycle%0d: tx=%b busy=%b, expected tx=%b busy=1",
                 tag, i, TX_OUT, BUSY, exp_q[i]);
      end
      if (mode == 1) begin
        P_DATA     = W'($urandom);
        PAR_EN     = 1'($urandom_range(0, 1));
        PAR_TYP    = 1'($urandom_range(0, 1));
        DATA_VALID = 1'($urandom_range(0, 1));
      end else if (mode == 0) begin
        DATA_VALID = 1'b0;
      end
    end
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_gap: tx=%b busy=%b, expected tx=1 busy=0",
               tag, TX_OUT, BUSY);
    end
    if (mode != 2) DATA_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold%0d: tx=%b busy=%b, expected tx=1 busy=0", i, TX_OUT, BUSY);
      end
    end
    DATA_VALID = 1'b0; RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL reset_release%0d: tx=%b busy=%b, expected tx=1 busy=0", i, TX_OUT, BUSY);
      end
    end
  endtask

  task automatic test_no_parity();
    logic [9:0] exp_bits;
    exp_bits = 10'b1_1010_0101_0;   // stop, data MSB..LSB, start (read LSB first)
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
      checks++;
      if (TX_OUT !== exp_bits[i] || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL a5_nopar cycle%0d: tx=%b busy=%b, expected tx=%b busy=1",
                 i, TX_OUT, BUSY, exp_bits[i]);
      end
    end
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL a5_nopar_end: tx=%b busy=%b, expected tx=1 busy=0", TX_OUT, BUSY);
    end
  endtask

  task automatic test_parity();
    run_frame(8'hA5, 1'b1, 1'b0, 0, "a5_even");
    run_frame(8'hA5, 1'b1, 1'b1, 0, "a5_odd");
    run_frame(8'h07, 1'b1, 1'b0, 1, "07_even_churn");
    run_frame(8'h07, 1'b1, 1'b1, 1, "07_odd_churn");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) run_frame(8'h3C, 1'b0, 1'b0, 2, "b2b_3c");
    DATA_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL b2b_release: tx=%b busy=%b, expected tx=1 busy=0", TX_OUT, BUSY);
    end
  endtask

  task automatic test_reset_mid_frame();
    P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin   // start bit, then data bits 0..3
      @(negedge CLK);
      DATA_VALID = 1'b0;
      checks++;
      if (TX_OUT !== 1'b0 || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_pre cycle%0d: tx=%b busy=%b, expected tx=0 busy=1", i, TX_OUT, BUSY);
      end
    end
    RST = 1'b0;
    DATA_VALID = 1'b1;   // reset must win over a simultaneous request
    @(negedge CLK);
    RST = 1'b1; DATA_VALID = 1'b0;
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_abort: tx=%b busy=%b, expected tx=1 busy=0", TX_OUT, BUSY);
    end
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_resume: tx=%b busy=%b, expected tx=1 busy=0", TX_OUT, BUSY);
    end
    run_frame(8'h81, 1'b0, 1'b0, 0, "after_rst_81");
  endtask

  task automatic test_random();
    int gap;
    for (int n = 0; n < 25; n++) begin
      run_frame(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 1), "random");
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
          errors++;
          $display("FAIL random_gap: tx=%b busy=%b, expected tx=1 busy=0", TX_OUT, BUSY);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
